apb3_requester_ctrl: RTL and testbench

RTL APB3 requester that turns a simple valid/ready command stream into APB3 SETUP/ACCESS transfers and returns a valid/ready response stream. It is the initiating end of the APB3 interface, so on-chip logic can drive APB3 completers such as the memory completer. In simulation its APB3 side connects to `renode_apb3_if` signals, in place of the Renode-driven requester.

---
 rtl/apb3_requester_ctrl_pkg.sv | 22 ++
 rtl/apb3_requester_ctrl.sv | 118 +++++++++++
 tb/tb_apb3_requester_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/apb3_requester_ctrl_pkg.sv
// Shared types for the APB3 requester: FSM state encoding and the captured
// response record.
package apb3_requester_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb3_req_state_e;

  // Sized for the widest legal bus; narrower instances use the low bits.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  error;
    logic                  timeout;
  } apb3_rsp_t;

endpackage

// File: rtl/apb3_requester_ctrl.sv
// APB3 requester: one valid/ready command becomes one SETUP/ACCESS transfer,
// answered by one valid/ready response. At most one transfer in flight.
module apb3_requester_ctrl
  import apb3_requester_pkg::*;
#(
  parameter int unsigned AddressWidth  = 20,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [AddressWidth-1:0] cmd_addr,
  input  logic [DataWidth-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [AddressWidth-1:0] paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [DataWidth-1:0]    pwdata,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned CntW    = ($clog2(TimeoutCycles + 1) < 1) ? 1 : $clog2(TimeoutCycles + 1);
  localparam int unsigned LastVal = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LastVal);
  localparam logic [CntW-1:0] CntMax  = '1;

  apb3_req_state_e         state_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [AddressWidth-1:0] paddr_q;
  logic                    pwrite_q;
  logic [DataWidth-1:0]    pwdata_q;
  logic                    psel_q, penable_q, rsp_valid_q;
  apb3_rsp_t               rsp_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          paddr_q  <= cmd_addr;
          pwrite_q <= cmd_write;
          pwdata_q <= cmd_write ? cmd_wdata : '0;
          psel_q   <= 1'b1;
          state_q  <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_q.rdata   <= pwrite_q ? '0 : DATA_W_DEF'(prdata);
            rsp_q.error   <= pslverr;
            rsp_q.timeout <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (TimeoutCycles != 0 && cnt_q == CntLast) begin
            // Completer never answered: abort and report a timeout error.
            rsp_q.rdata   <= '0;
            rsp_q.error   <= 1'b1;
            rsp_q.timeout <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so cmd_ready stays low while reset is held.
  assign cmd_ready   = rst_n & (state_q == IDLE);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata[DataWidth-1:0];
  assign rsp_error   = rsp_q.error;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb3_requester_ctrl.sv
// Randomized bench: the bench plays command source, APB3 completer and
// response sink, and predicts each response from a word-level memory model.
module tb_apb3_requester_ctrl;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int T  = 8;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready, pslverr;
  logic [DW-1:0] pwdata, prdata;

  apb3_requester_ctrl #(.AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mem     [16];  // completer storage, written from observed pwdata
  logic [31:0] ref_mem [16];  // expected contents, written from command data

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input bit err, input int rdly);
    int          acc;
    bit          exp_to, exp_err;
    logic [31:0] exp_rd;
    exp_to  = (waits >= T);
    acc     = exp_to ? T : waits + 1;
    exp_err = exp_to ? 1'b1 : err;
    exp_rd  = (wr || exp_to) ? 32'h0 : ref_mem[a[5:2]];
    if (wr && !exp_to && !err) ref_mem[a[5:2]] = d;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_write = 1'($urandom);
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, wr ? d : 32'h0);

    for (int i = 0; i < acc; i++) begin
      @(posedge clk); @(negedge clk);
      chk("acc_psel", psel, 1);
      chk("acc_penable", penable, 1);
      chk("acc_paddr", paddr, a);
      chk("acc_pwrite", pwrite, wr);
      if (i == waits) begin
        pready = 1'b1; pslverr = err; prdata = mem[a[5:2]];
        if (wr && !err) mem[a[5:2]] = pwdata;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end
      rsp_ready = (i == acc - 1) && (rdly == 0);
    end

    @(posedge clk); @(negedge clk);
    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_error", rsp_error, exp_err);
    chk("resp_timeout", rsp_timeout, exp_to);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rdata", rsp_rdata, exp_rd);
      chk("bp_error", rsp_error, exp_err);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #3;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);

    xfer(1'b1, 20'h00010, 32'hDEADBEEF, 0, 1'b0, 0);
    xfer(1'b0, 20'h00010, 32'h0, 0, 1'b0, 0);
    xfer(1'b0, 20'h00010, 32'h0, 3, 1'b0, 0);
    xfer(1'b1, 20'h00020, 32'h12345678, 1, 1'b1, 0);
    xfer(1'b0, 20'h00020, 32'h0, 0, 1'b0, 0);
    xfer(1'b0, 20'h00010, 32'h0, 40, 1'b0, 0);
    xfer(1'b0, 20'h00010, 32'h0, T - 1, 1'b0, 0);
    xfer(1'b1, 20'h00014, 32'hCAFEF00D, 1, 1'b0, 5);

    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      a = {14'($urandom), 4'($urandom), 2'b00};
      xfer(1'($urandom), a, $urandom,
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 2)),
           ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of ACCESS; the write must be discarded.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00018; cmd_wdata = 32'hBAD0BAD0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_penable", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_paddr", paddr, 0);
    chk("mid_rst_pwrite", pwrite, 0);
    chk("mid_rst_pwdata", pwdata, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_error, rsp_timeout}, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("after_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    xfer(1'b0, 20'h00018, 32'h0, 0, 1'b0, 0);
    xfer(1'b0, 20'h00010, 32'h0, 2, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
